uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Parametrised UART receive controller: synchroniser, oversampling bit timer, majority-vote sampler, frame state machine and deserialiser in one block. It replaces the fixed-format receive FSM plus separate counter, sampler and checker blocks. Data length (5–`MAX_DATA_W`), parity mode, stop-bit count and oversampling ratio are run-time configurable and latched per frame. Completed frames are reported with status flags.

## Interface
- `MAX_DATA_W`, 8, maximum data bits per frame (legal 5–9)
- `PRESC_W`, 6, width of prescale input
- `clk`  in  1  receive clock, `prescale` cycles per bit
- `rst`  in  1  synchronous, active-high reset
- `rx_in`  in  1  asynchronous serial line; idles high
- `prescale`  in  `PRESC_W`  cycles per bit; even, 8–32
- `data_len`  in  4  data bits per frame, 5–`MAX_DATA_W`
- `par_mode`  in  2  00 none, 01 even, 10 odd, 11 none
- `stop2`  in  1  0: one stop bit; 1: two stop bits
- `rx_data`  out  `MAX_DATA_W`  received word, LSB = first bit received; bits ≥ `data_len` read 0
- `data_valid`  out  1  one-cycle pulse: good frame on `rx_data`
- `frame_done`  out  1  one-cycle pulse at every frame end, good or bad
- `par_err`  out  1  valid with `frame_done`: parity mismatch
- `frm_err`  out  1  valid with `frame_done`: a stop bit sampled 0
- `strt_glitch`  out  1  one-cycle pulse: start bit rejected
- `busy`  out  1  state ≠ IDLE

## Operation
- `rx_in` passes through a 2-flop synchroniser; both flops reset to 1. The synchroniser output is `rx_s`.
- Configuration is latched on the IDLE→START transition and ignored for the rest of the frame.
  - Odd `prescale`: LSB is forced to 0.
  - `prescale` < 8: treated as 8.
  - `data_len` < 5: treated as 5.
  - `data_len` > `MAX_DATA_W`: treated as `MAX_DATA_W`.
- `edge_cnt` runs 0..P−1 within each bit and wraps to 0, where P is the latched prescale.
- Each bit is sampled at `edge_cnt` = P/2−1, P/2 and P/2+1. The bit value is the majority of the three samples, decided in the cycle with `edge_cnt` = P/2+1.
- State machine:
  - IDLE: on `rx_s`=0 → START. The cycle that sees `rx_s`=0 counts as `edge_cnt` 0.
  - START: decision 1 → `strt_glitch` pulse, go to IDLE. At `edge_cnt`=P−1 → DATA, `bit_cnt`=0.
  - DATA: at each decision, shift the bit in LSB-first and increment `bit_cnt`. At `edge_cnt`=P−1 with `bit_cnt`=`data_len`:
    - → PARITY if parity is enabled,
    - → STOP otherwise.
  - PARITY: the decision is compared against the XOR of the data bits (even mode) or its inverse (odd mode); a mismatch sets `par_err`. At `edge_cnt`=P−1 → STOP.
  - STOP: decision 0 sets `frm_err`.
    - With `stop2`=1, the first stop bit runs a full P cycles before the second.
    - At the decision of the last stop bit, the block ends the frame immediately and returns to IDLE. It does not wait out the rest of the bit, so it can resynchronise on the next start edge.
- Frame end:
  - `frame_done` pulses with `par_err`/`frm_err` valid in the same cycle.
  - `data_valid` pulses only if both error flags are 0.
  - `rx_data` updates only on `data_valid` and holds until the next good frame.
- Error flags hold 0 outside the `frame_done` cycle.

## Timing
- Reset state: IDLE; all counters 0; `rx_data`=0; every pulse output and `busy` = 0.
- Reset mid-frame aborts the frame with no pulses. The first cycle after reset is IDLE.
- `rx_s` lags `rx_in` by 2 cycles.
- Let c0 be the first cycle in which IDLE sees `rx_s`=0.
  - The decision for frame bit k (start bit = 0) occurs in cycle c0 + k·P + P/2 + 1.
  - Registered outputs for that decision appear one cycle later.
  - `strt_glitch` appears in cycle c0 + P/2 + 2. IDLE resumes in the same cycle.
- A start edge is accepted in the first cycle after the frame end, i.e. the first IDLE cycle.
- A falling edge that occurs during STOP after the decision is handled in IDLE, with no loss.

## Structure
- `uart_rx_pkg`: state encoding enum; parity-mode constants; `MIN_PRESCALE`=8; `MIN_DATA_W`=5.
- Sub-module `uart_rx_sampler`: contains the `edge_cnt` counter, the three-sample capture and the majority vote. Its outputs are `bit_val`, `bit_strobe` and `bit_end`.
- The FSM, deserialiser and parity accumulator live in `uart_rx_ctrl`.

## Test plan
- P=8, 8N1, byte 0xA5:
  - `data_valid` and `frame_done` high exactly 80 cycles after the first clock edge that samples `rx_in` low.
  - `rx_data`=0xA5; `par_err`=`frm_err`=0.
- P=16, 7 bits, odd parity, `stop2`=1, data 0x35 with correct parity:
  - `rx_data`=0x35.
  - Repeat with the parity bit flipped → `frame_done`+`par_err`, no `data_valid`, `rx_data` unchanged.
- P=8, 8N1, stop bit driven 0 → `frame_done` with `frm_err`=1, no `data_valid`.
- `rx_in` low for 3 cycles only, with P=16 → one `strt_glitch` pulse, back to IDLE, no `frame_done`.
- Back-to-back frames 0x00 then 0xFF (8N1, P=8) with the next start bit directly after the stop bit → two `data_valid` pulses exactly 80 cycles apart.
- `rst` asserted during DATA → all outputs 0 next cycle. A following clean frame with 0x3C yields `rx_data`=0x3C.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// uart_rx_pkg : shared state encoding, parity modes and config limits for the UART receiver
// Rev 1.0
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE     = 2'b00;
  localparam logic [1:0] PAR_EVEN     = 2'b01;
  localparam logic [1:0] PAR_ODD      = 2'b10;
  localparam logic [1:0] PAR_NONE_ALT = 2'b11;

  localparam int MIN_PRESCALE = 8;
  localparam int MIN_DATA_W   = 5;

  function automatic logic parity_enabled(input logic [1:0] mode);
    logic en;
    case (mode)
      PAR_EVEN, PAR_ODD:      en = 1'b1;
      PAR_NONE, PAR_NONE_ALT: en = 1'b0;
      default:                en = 1'b0;
    endcase
    return en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// uart_rx_sampler : per-bit edge counter with three-point majority-vote sampling
// Rev 1.0
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               rx_s,
  input  logic [PRESC_W-1:0] prescale,
  output logic               bit_val,
  output logic               bit_strobe,
  output logic               bit_end
);

  localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] half;
  logic [PRESC_W-1:0] last;
  logic               s0;
  logic               s1;

  assign half = {1'b0, prescale[PRESC_W-1:1]};
  assign last = prescale - P_ONE;

  // Counter is held at 0 while the frame logic is idle, so the start-edge cycle is count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
    end else begin
      if (!run) begin
        edge_cnt <= '0;
      end else if (edge_cnt == last) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + P_ONE;
      end
      if (edge_cnt == half - P_ONE) s0 <= rx_s;
      if (edge_cnt == half)         s1 <= rx_s;
    end
  end

  // Third sample is the live line value in the decision cycle.
  assign bit_val    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign bit_strobe = (edge_cnt == half + P_ONE);
  assign bit_end    = (edge_cnt == last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// uart_rx_ctrl : configurable UART receiver - synchroniser, frame FSM, deserialiser, status flags
// Rev 1.0
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int MAX_DATA_W = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [3:0]            data_len,
  input  logic [1:0]            par_mode,
  input  logic                  stop2,
  output logic [MAX_DATA_W-1:0] rx_data,
  output logic                  data_valid,
  output logic                  frame_done,
  output logic                  par_err,
  output logic                  frm_err,
  output logic                  strt_glitch,
  output logic                  busy
);

  localparam logic [PRESC_W-1:0] P_ONE   = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] P_MIN   = PRESC_W'(MIN_PRESCALE);
  localparam logic [3:0]         LEN_MIN = 4'(MIN_DATA_W);
  localparam logic [3:0]         LEN_MAX = 4'(MAX_DATA_W);

  state_t                state;
  state_t                state_nx;
  logic                  sync_q;
  logic                  rx_s;
  logic [PRESC_W-1:0]    presc_even;
  logic [PRESC_W-1:0]    presc_eff;
  logic [PRESC_W-1:0]    p_lat;
  logic [3:0]            len_eff;
  logic [3:0]            len_lat;
  logic [3:0]            bit_cnt;
  logic [1:0]            par_lat;
  logic                  stop2_lat;
  logic                  second_stop;
  logic                  par_acc;
  logic                  par_bad;
  logic                  stop_bad;
  logic [MAX_DATA_W-1:0] shreg;
  logic                  bit_val;
  logic                  bit_strobe;
  logic                  bit_end;
  logic                  run;
  logic                  start_edge;
  logic                  frame_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= rx_in;
      rx_s   <= sync_q;
    end
  end

  assign presc_even = prescale & ~P_ONE;
  assign presc_eff  = (presc_even < P_MIN) ? P_MIN : presc_even;
  assign len_eff    = (data_len < LEN_MIN) ? LEN_MIN :
                      (data_len > LEN_MAX) ? LEN_MAX : data_len;

  assign start_edge = (state == ST_IDLE) && !rx_s;
  assign frame_end  = (state == ST_STOP) && bit_strobe && (!stop2_lat || second_stop);
  assign run        = (state_nx != ST_IDLE);
  assign busy       = (state != ST_IDLE);

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .rx_s       (rx_s),
    .prescale   (p_lat),
    .bit_val    (bit_val),
    .bit_strobe (bit_strobe),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (!rx_s) state_nx = ST_START;
      ST_START: begin
        if (bit_strobe && bit_val) state_nx = ST_IDLE;
        else if (bit_end)          state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_cnt == len_lat))
          state_nx = parity_enabled(par_lat) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end) state_nx = ST_STOP;
      // The frame ends mid-bit on the last stop decision so the next start edge is not missed.
      ST_STOP:   if (frame_end) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_lat       <= P_MIN;
      len_lat     <= LEN_MIN;
      par_lat     <= PAR_NONE;
      stop2_lat   <= 1'b0;
      bit_cnt     <= '0;
      second_stop <= 1'b0;
      par_acc     <= 1'b0;
      par_bad     <= 1'b0;
      stop_bad    <= 1'b0;
      shreg       <= '0;
      rx_data     <= '0;
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
      strt_glitch <= 1'b0;
      if (start_edge) begin
        p_lat       <= presc_eff;
        len_lat     <= len_eff;
        par_lat     <= par_mode;
        stop2_lat   <= stop2;
        bit_cnt     <= '0;
        second_stop <= 1'b0;
        par_acc     <= 1'b0;
        par_bad     <= 1'b0;
        stop_bad    <= 1'b0;
        shreg       <= '0;
      end
      if ((state == ST_START) && bit_strobe && bit_val) strt_glitch <= 1'b1;
      if ((state == ST_DATA) && bit_strobe) begin
        shreg   <= shreg | (MAX_DATA_W'(bit_val) << bit_cnt);
        par_acc <= par_acc ^ bit_val;
        bit_cnt <= bit_cnt + 4'd1;
      end
      if ((state == ST_PARITY) && bit_strobe &&
          (bit_val != (par_acc ^ (par_lat == PAR_ODD))))
        par_bad <= 1'b1;
      if ((state == ST_STOP) && bit_strobe && !bit_val) stop_bad <= 1'b1;
      if ((state == ST_STOP) && bit_end && stop2_lat) second_stop <= 1'b1;
      if (frame_end) begin
        frame_done <= 1'b1;
        par_err    <= par_bad;
        frm_err    <= stop_bad | ~bit_val;
        if (!par_bad && !stop_bad && bit_val) begin
          data_valid <= 1'b1;
          rx_data    <= shreg;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// tb_uart_rx_ctrl : directed and randomized frames checked against a frame-level reference model
// Rev 1.0
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic [3:0] data_len;
  logic [1:0] par_mode;
  logic       stop2;
  logic [7:0] rx_data;
  logic       data_valid, frame_done, par_err, frm_err, strt_glitch, busy;

  uart_rx_ctrl #(.MAX_DATA_W(8), .PRESC_W(6)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .data_len(data_len),
    .par_mode(par_mode), .stop2(stop2), .rx_data(rx_data), .data_valid(data_valid),
    .frame_done(frame_done), .par_err(par_err), .frm_err(frm_err),
    .strt_glitch(strt_glitch), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int stray = 0;
  int last_dv = 0;
  int prev_dv = 0;
  logic [7:0] exp_rx = 8'h00;

  // observed events
  int fd_cyc[$]; bit fd_pe[$]; bit fd_fe[$];
  int dv_cyc[$]; logic [7:0] dv_d[$];
  int gl_cyc[$];
  // expected frame results
  int xq_cyc[$]; bit xq_pe[$]; bit xq_fe[$]; bit xq_dv[$]; logic [7:0] xq_d[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) begin
        fd_cyc.push_back(cyc); fd_pe.push_back(par_err); fd_fe.push_back(frm_err);
      end
      if (data_valid) begin
        dv_cyc.push_back(cyc); dv_d.push_back(rx_data);
        if (!frame_done) stray++;
      end
      if ((par_err || frm_err) && !frame_done) stray++;
      if (strt_glitch) gl_cyc.push_back(cyc);
    end
  end

  function automatic int eff_p(input int p);
    int q;
    q = p - (p % 2);
    return (q < 8) ? 8 : q;
  endfunction

  function automatic int eff_len(input int l);
    return (l < 5) ? 5 : ((l > 8) ? 8 : l);
  endfunction

  task automatic drive_bit(input logic b, input int n);
    rx_in = b;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one frame bit-serially and queues the result the receiver must report.
  task automatic run_frame(input int p_in, input int len_in, input int pm, input bit s2,
                           input logic [8:0] data, input bit flip, input bit bad,
                           input int gap, output int e);
    int p, len, nst, nbits, c0;
    bit pen, pe;
    logic [8:0] d;
    logic pbit;
    p   = eff_p(p_in);
    len = eff_len(len_in);
    pen = (pm == 1) || (pm == 2);
    nst = s2 ? 2 : 1;
    d   = '0;
    for (int i = 0; i < len; i++) d[i] = data[i];
    pbit = (^d) ^ (pm == 2);
    prescale = p_in[5:0]; data_len = len_in[3:0]; par_mode = pm[1:0]; stop2 = s2;
    e  = cyc + 1;          // first posedge that samples the start bit
    c0 = e + 1;            // first cycle the FSM sees the synchronised low
    drive_bit(1'b0, p);
    for (int i = 0; i < len; i++) drive_bit(data[i], p);
    if (pen) drive_bit(pbit ^ flip, p);
    for (int s = 0; s < nst; s++) begin
      if (bad && s == nst - 1) begin
        drive_bit(1'b0, p / 2 + 2);
        drive_bit(1'b1, p - p / 2 - 2);
      end else begin
        drive_bit(1'b1, p);
      end
    end
    nbits = 1 + len + (pen ? 1 : 0) + nst;
    pe = pen && flip;
    xq_cyc.push_back(c0 + (nbits - 1) * p + p / 2 + 2);
    xq_pe.push_back(pe); xq_fe.push_back(bad); xq_dv.push_back(!pe && !bad);
    xq_d.push_back(d[7:0]);
    if (!pe && !bad) exp_rx = d[7:0];
    drive_bit(1'b1, gap);
  endtask

  task automatic check_frames(input string tag);
    int xc, oc;
    bit xpe, xfe, xdv;
    logic [7:0] xd, od;
    while (xq_cyc.size() > 0) begin
      xc = xq_cyc.pop_front(); xpe = xq_pe.pop_front(); xfe = xq_fe.pop_front();
      xdv = xq_dv.pop_front(); xd = xq_d.pop_front();
      check({tag, "_fd_seen"}, fd_cyc.size() != 0, 1);
      if (fd_cyc.size() != 0) begin
        oc = fd_cyc.pop_front();
        check({tag, "_fd_cyc"}, oc, xc);
        check({tag, "_par_err"}, fd_pe.pop_front(), xpe);
        check({tag, "_frm_err"}, fd_fe.pop_front(), xfe);
      end
      if (xdv) begin
        check({tag, "_dv_seen"}, dv_cyc.size() != 0, 1);
        if (dv_cyc.size() != 0) begin
          oc = dv_cyc.pop_front(); od = dv_d.pop_front();
          check({tag, "_dv_cyc"}, oc, xc);
          check({tag, "_dv_data"}, od, xd);
          prev_dv = last_dv; last_dv = oc;
        end
      end
    end
    check({tag, "_extra_fd"}, fd_cyc.size(), 0);
    check({tag, "_extra_dv"}, dv_cyc.size(), 0);
    check({tag, "_glitch_none"}, gl_cyc.size(), 0);
    check({tag, "_rx_hold"}, rx_data, exp_rx);
    check({tag, "_idle"}, busy, 0);
    fd_cyc.delete(); fd_pe.delete(); fd_fe.delete(); dv_cyc.delete(); dv_d.delete();
    gl_cyc.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst = 1'b1; rx_in = 1'b1; prescale = 6'd8; data_len = 4'd8; par_mode = 2'b00; stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {rx_data, data_valid, frame_done, par_err, frm_err, strt_glitch, busy}, 0);
    @(posedge clk); #1;
    drive_bit(1'b1, 4);

    // 8N1 at P=8: launched by posedge E+79, so first sampled high 80 edges after E
    run_frame(8, 8, 0, 0, 9'h0A5, 0, 0, 6, e);
    check_frames("a5");
    check("a5_latency", last_dv - e, 79);

    run_frame(16, 7, 2, 1, 9'h035, 0, 0, 6, e);
    check_frames("odd7_good");
    run_frame(16, 7, 2, 1, 9'h035, 1, 0, 6, e);
    check_frames("odd7_flip");

    run_frame(8, 8, 0, 0, 9'h05A, 0, 1, 6, e);
    check_frames("bad_stop");

    // three-cycle low pulse must be rejected as a start glitch
    prescale = 6'd16;
    e = cyc + 1;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 30);
    check("glitch_count", gl_cyc.size(), 1);
    if (gl_cyc.size() != 0) check("glitch_cyc", gl_cyc[0], e + 1 + 8 + 2);
    gl_cyc.delete();
    check_frames("glitch");

    run_frame(8, 8, 0, 0, 9'h000, 0, 0, 0, e);
    run_frame(8, 8, 0, 0, 9'h0FF, 0, 0, 6, e);
    check_frames("b2b");
    check("b2b_spacing", last_dv - prev_dv, 80);

    // reset in the middle of the data bits
    prescale = 6'd8; data_len = 4'd8; par_mode = 2'b00; stop2 = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 12);
    rst = 1'b1; rx_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_outs", {rx_data, data_valid, frame_done, par_err, frm_err, strt_glitch, busy}, 0);
    @(posedge clk); #1 rst = 1'b0;
    exp_rx = 8'h00;
    drive_bit(1'b1, 20);
    check_frames("midrst_quiet");
    run_frame(8, 8, 0, 0, 9'h03C, 0, 0, 6, e);
    check_frames("after_rst");

    for (int k = 0; k < 24; k++) begin
      int p_in, len_in, pm, gap;
      bit s2, flip, bad;
      logic [8:0] d;
      p_in   = $urandom_range(5, 33);
      len_in = $urandom_range(3, 10);
      pm     = $urandom_range(0, 3);
      s2     = 1'($urandom_range(0, 1));
      d      = 9'($urandom);
      flip   = ($urandom_range(0, 3) == 0);
      bad    = ($urandom_range(0, 5) == 0);
      gap    = $urandom_range(2, 12);
      run_frame(p_in, len_in, pm, s2, d, flip, bad, gap, e);
      check_frames("rand");
    end

    check("stray_flags", stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
